// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_if
// Purpose  : Command/response and APB bus bundle for the APB requester.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 128
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Converts valid/ready commands into APB SETUP/ACCESS transfers,
//            one response per command, with an optional wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        PCLK,
    input  wire logic        PRESETn,
    apb_master_if.master     bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;

    // A zero timeout still needs a one-bit counter to keep the logic legal.
    localparam int                 c_CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_rsp_timeout;
    logic                  w_cmd_ready;

    assign w_cmd_ready = (r_state == c_IDLE) && PRESETn;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= c_IDLE;
            r_wait_cnt    <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.cmd_valid && w_cmd_ready) begin
                        r_pwrite  <= bus.cmd_write;
                        r_paddr   <= bus.cmd_addr;
                        r_pwdata  <= bus.cmd_write ? bus.cmd_wdata : '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= c_ACCESS;
                end
                c_ACCESS: begin
                    if (bus.PREADY) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_error   <= bus.PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= c_IDLE;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_wait_cnt == c_TIMEOUT)) begin
                        // Slave stalled too long: abort and report as an error.
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_error   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= c_IDLE;
                    end else if (r_wait_cnt != c_CNT_MAX) begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.PSELx       = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule
`default_nettype wire
